// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the requesters / FIFO write port and the round-robin arbiter.
// Handshake: requester k presents a word by raising i_req[k] with i_data slice k
// (and i_last[k] on the final word) and holds them stable. The word is taken
// in the cycle where o_ack[k] is high, and the same cycle shows o_wr/o_wdata to
// the FIFO. A requester may drop i_req[k] before its ack; that ends its grant.
// i_wfull stalls acceptance without dropping the grant.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        i_last;
  logic                      i_wfull;
  logic [NUM_REQ-1:0]        o_ack;
  logic                      o_wr;
  logic [DATA_W-1:0]         o_wdata;
  logic [OWNER_W-1:0]        o_owner;
  logic                      o_busy;
  // FSM visibility for checkers: state (0=IDLE, 1=GRANT) and burst count
  logic                      dbg_state;
  logic [CNT_W-1:0]          dbg_cnt;

  modport master (
    output i_req, i_data, i_last, i_wfull,
    input  o_ack, o_wr, o_wdata, o_owner, o_busy, dbg_state, dbg_cnt
  );

  modport slave (
    input  i_req, i_data, i_last, i_wfull,
    output o_ack, o_wr, o_wdata, o_owner, o_busy, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts up to MAX_BURST words, ends early on i_last or withdrawal,
// and is followed by exactly one IDLE cycle in which the next winner is chosen.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [OWNER_W-1:0] owner, owner_nxt;
  logic [OWNER_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic [OWNER_W-1:0] winner;
  logic               found;
  int                 arb_idx;
  logic [OWNER_W-1:0] arb_sel;

  logic               req_own;
  logic               last_own;
  logic               accept;
  logic               rel;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  // Split the flat data bus into one word per requester
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = bus.i_data[k*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    arb_idx = 0;
    arb_sel = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = (int'(rr_ptr) + i) % NUM_REQ;
      arb_sel = OWNER_W'(arb_idx);
      if (!found && bus.i_req[arb_sel]) begin
        winner = arb_sel;
        found  = 1'b1;
      end
    end
  end

  // Owner handshake decode; reset gates the write so no word lands mid-reset
  always_comb begin
    req_own  = bus.i_req[owner];
    last_own = bus.i_last[owner];
    accept   = rst_n && (state == GRANT) && req_own && !bus.i_wfull;
    // Withdrawal releases even while full; a full stall otherwise holds the grant
    rel      = (state == GRANT) &&
               (!req_own || (accept && (last_own || (cnt == CNT_W'(MAX_BURST - 1)))));
  end

  // Next-state logic for the IDLE/GRANT FSM and its registers
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner;
        end else if (accept) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= OWNER_W'(NUM_REQ - 1);
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Combinational write port and ack; zero whenever nothing is accepted
  always_comb begin
    bus.o_wr    = accept;
    bus.o_ack   = accept ? (NUM_REQ'(1) << owner) : '0;
    bus.o_wdata = accept ? data_arr[owner] : '0;
  end

  assign bus.o_owner   = owner;
  assign bus.o_busy    = (state == GRANT);
  assign bus.dbg_state = state;
  assign bus.dbg_cnt   = cnt;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word queues drive the
// inputs, a 16-deep FIFO occupancy model drives i_wfull, and a negedge monitor
// pops the expected {owner, data} queue on every write.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int OWNER_W   = 2;
  localparam int DEPTH     = 16;
  localparam int W         = OWNER_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- bench state ----------------
  logic [W-1:0]      exp_q[$];
  logic [DATA_W:0]   src_q [NUM_REQ][$];   // {last, data}
  int                wr_cyc[$];
  int                cyc = 0;
  int                occ = 0;
  logic              rd_en = 1'b1;
  logic              force_full = 1'b0;
  logic [NUM_REQ-1:0] acked;
  logic              wr_seen;
  logic [W-1:0]      mon_e;
  int                n_cmp = 0;
  int                n_err = 0;
  int                base;
  int                n;

  function automatic logic [31:0] mk(input int t, input int k, input int i);
    return (32'(t) << 24) | (32'(k) << 16) | 32'(i);
  endfunction

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) if (src_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_src(input int k, input logic [31:0] d, input logic last);
    src_q[k].push_back({last, d});
  endtask

  task automatic push_exp(input int k, input logic [31:0] d);
    exp_q.push_back({OWNER_W'(k), d});
  endtask

  task automatic drive();
    logic [DATA_W:0] h;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src_q[k].size() > 0) begin
        h = src_q[k][0];
        bus.i_req[k]                    = 1'b1;
        bus.i_data[k*DATA_W +: DATA_W]  = h[DATA_W-1:0];
        bus.i_last[k]                   = h[DATA_W];
      end else begin
        bus.i_req[k]                    = 1'b0;
        bus.i_data[k*DATA_W +: DATA_W]  = '0;
        bus.i_last[k]                   = 1'b0;
      end
    end
    bus.i_wfull = force_full || (occ >= DEPTH);
  endtask

  // One clock: see acks before the edge, retire accepted words after it
  task automatic tick();
    bit rd_ok;
    @(negedge clk_in);
    acked   = bus.o_ack;
    wr_seen = bus.o_wr;
    @(posedge clk_in);
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      if (acked[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    rd_ok = rd_en && (occ > 0);
    occ   = occ + (wr_seen ? 1 : 0) - (rd_ok ? 1 : 0);
    cyc++;
    drive();
  endtask

  task automatic run_idle(input string name, input int max);
    int k = 0;
    while (!(exp_q.size() == 0 && !bus.o_busy && srcs_empty()) && k < max) begin
      tick();
      k++;
    end
    chk({name, "_completes"}, 64'(k < max), 64'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    if (bus.o_wr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: owner %0d data 0x%0h, expected none", bus.o_owner, bus.o_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_owner_data", 64'({bus.o_owner, bus.o_wdata}), 64'(mon_e));
        chk("wr_ack_onehot", 64'(bus.o_ack), 64'd1 << mon_e[W-1:DATA_W]);
      end
      chk("wr_not_when_full", 64'(occ < DEPTH), 64'd1);
      wr_cyc.push_back(cyc);
    end else if (bus.o_ack != '0) begin
      chk("ack_without_wr", 64'(bus.o_ack), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_req = '0; bus.i_data = '0; bus.i_last = '0; bus.i_wfull = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_busy",  64'(bus.o_busy),    64'd0);
    chk("reset_owner", 64'(bus.o_owner),   64'd0);
    chk("reset_state", 64'(bus.dbg_state), 64'd0);
    chk("reset_cnt",   64'(bus.dbg_cnt),   64'd0);
    chk("reset_wr",    64'(bus.o_wr),      64'd0);
    rst_n = 1'b1;

    // T1: single requester, 3-word packet ending on i_last
    base = wr_cyc.size();
    push_src(0, 32'd1, 1'b0); push_src(0, 32'd2, 1'b0); push_src(0, 32'd3, 1'b1);
    push_exp(0, 32'd1); push_exp(0, 32'd2); push_exp(0, 32'd3);
    drive();
    #1;
    chk("t1_busy_before_grant", 64'(bus.o_busy), 64'd0);
    tick();
    chk("t1_busy_after_1cycle", 64'(bus.o_busy),  64'd1);
    chk("t1_owner",             64'(bus.o_owner), 64'd0);
    run_idle("t1", 20);
    chk("t1_write_count", 64'(wr_cyc.size() - base), 64'd3);
    if (wr_cyc.size() - base == 3)
      chk("t1_back_to_back", 64'(wr_cyc[base+2] - wr_cyc[base]), 64'd2);

    // T2: req0 and req2 continuous; rr_ptr=0 so req2 goes first, bursts of 4
    base = wr_cyc.size();
    for (int i = 0; i < 8; i++) begin
      push_src(0, mk(2, 0, i), 1'b0);
      push_src(2, mk(2, 2, i), 1'b0);
    end
    for (int i = 0; i < 4; i++) push_exp(2, mk(2, 2, i));
    for (int i = 0; i < 4; i++) push_exp(0, mk(2, 0, i));
    for (int i = 4; i < 8; i++) push_exp(2, mk(2, 2, i));
    for (int i = 4; i < 8; i++) push_exp(0, mk(2, 0, i));
    drive();
    run_idle("t2", 60);
    chk("t2_write_count", 64'(wr_cyc.size() - base), 64'd16);
    if (wr_cyc.size() - base == 16)
      for (int i = 1; i < 16; i++)
        chk("t2_burst_spacing", 64'(wr_cyc[base+i] - wr_cyc[base+i-1]), (i % 4 == 0) ? 64'd2 : 64'd1);

    // T3: owner 1 stalled by full for 5 cycles after 2 words
    base = wr_cyc.size();
    for (int i = 0; i < 4; i++) begin
      push_src(1, mk(3, 1, i), 1'b0);
      push_exp(1, mk(3, 1, i));
    end
    drive();
    n = 0;
    while (wr_cyc.size() < base + 2 && n < 20) begin tick(); n++; end
    chk("t3_two_words_before_full", 64'(wr_cyc.size() - base), 64'd2);
    force_full = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_wr",    64'(bus.o_wr),    64'd0);
      chk("t3_stall_ack",   64'(bus.o_ack),   64'd0);
      chk("t3_stall_owner", 64'(bus.o_owner), 64'd1);
      chk("t3_stall_cnt",   64'(bus.dbg_cnt), 64'd2);
      tick();
    end
    force_full = 1'b0;
    drive();
    run_idle("t3", 20);
    chk("t3_write_count", 64'(wr_cyc.size() - base), 64'd4);
    if (wr_cyc.size() - base == 4) begin
      chk("t3_resume_gap", 64'(wr_cyc[base+2] - wr_cyc[base+1]), 64'd6);
      chk("t3_resume_b2b", 64'(wr_cyc[base+3] - wr_cyc[base+2]), 64'd1);
    end

    // T4: owner 3 withdraws after one word, req0 waiting; pointer wraps 3->0
    base = wr_cyc.size();
    push_src(3, mk(4, 3, 0), 1'b0);
    push_exp(3, mk(4, 3, 0));
    drive();
    tick();
    chk("t4_owner3", 64'(bus.o_owner), 64'd3);
    push_src(0, mk(4, 0, 0), 1'b0); push_src(0, mk(4, 0, 1), 1'b1);
    push_exp(0, mk(4, 0, 0));       push_exp(0, mk(4, 0, 1));
    drive();
    run_idle("t4", 20);
    chk("t4_write_count", 64'(wr_cyc.size() - base), 64'd3);
    if (wr_cyc.size() - base == 3)
      chk("t4_withdraw_gap", 64'(wr_cyc[base+1] - wr_cyc[base]), 64'd3);

    // T5: fill the 16-deep FIFO with reads off, then drain
    tick(); tick();
    rd_en = 1'b0;
    base  = wr_cyc.size();
    for (int i = 0; i < 10; i++) begin
      push_src(0, mk(5, 0, i), 1'b0);
      push_src(1, mk(5, 1, i), 1'b0);
    end
    for (int i = 0; i < 4; i++) push_exp(1, mk(5, 1, i));
    for (int i = 0; i < 4; i++) push_exp(0, mk(5, 0, i));
    for (int i = 4; i < 8; i++) push_exp(1, mk(5, 1, i));
    for (int i = 4; i < 8; i++) push_exp(0, mk(5, 0, i));
    push_exp(1, mk(5, 1, 8)); push_exp(1, mk(5, 1, 9));
    push_exp(0, mk(5, 0, 8)); push_exp(0, mk(5, 0, 9));
    drive();
    repeat (40) tick();
    #1;
    chk("t5_writes_until_full", 64'(wr_cyc.size() - base), 64'd16);
    chk("t5_full_flag",         64'(bus.i_wfull),          64'd1);
    chk("t5_busy_stalled",      64'(bus.o_busy),           64'd1);
    chk("t5_owner_stalled",     64'(bus.o_owner),          64'd1);
    chk("t5_no_wr_when_full",   64'(bus.o_wr),             64'd0);
    rd_en = 1'b1;
    run_idle("t5", 60);
    chk("t5_total_writes", 64'(wr_cyc.size() - base), 64'd20);

    // T6: reset during owner 2's second word; next grant goes to requester 1
    base = wr_cyc.size();
    for (int i = 0; i < 4; i++) push_src(2, mk(6, 2, i), 1'b0);
    push_exp(2, mk(6, 2, 0));
    drive();
    n = 0;
    while (wr_cyc.size() < base + 1 && n < 20) begin tick(); n++; end
    chk("t6_first_word", 64'(wr_cyc.size() - base), 64'd1);
    rst_n = 1'b0;
    push_src(1, mk(6, 1, 0), 1'b0); push_src(1, mk(6, 1, 1), 1'b1);
    drive();
    #1;
    chk("t6_reset_wr",    64'(bus.o_wr),    64'd0);
    chk("t6_reset_ack",   64'(bus.o_ack),   64'd0);
    chk("t6_reset_wdata", 64'(bus.o_wdata), 64'd0);
    tick();
    rst_n = 1'b0;
    rst_n = 1'b1;
    chk("t6_after_reset_busy",  64'(bus.o_busy),    64'd0);
    chk("t6_after_reset_state", 64'(bus.dbg_state), 64'd0);
    push_exp(1, mk(6, 1, 0)); push_exp(1, mk(6, 1, 1));
    for (int i = 1; i < 4; i++) push_exp(2, mk(6, 2, i));
    drive();
    tick();
    chk("t6_grant_req1", 64'(bus.o_owner), 64'd1);
    run_idle("t6", 30);
    chk("t6_write_count", 64'(wr_cyc.size() - base), 64'd6);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
